// File: rtl/pipeline_stage_register.sv
// One-stage pipeline register with valid/ready handshake and a one-entry skid
// buffer. Both the data path and the backpressure path are registered:
// in_ready depends only on the held state, never on out_ready in the same cycle.
//
// Handshake: a word moves across an interface on a rising clk edge when valid
// and ready are both high on that edge. A producer keeps valid and data steady
// until the word is taken; this stage never withdraws out_valid or changes
// out_data while out_valid=1 and out_ready=0.
//
// States: EMPTY (nothing held), BUSY (main holds a word), FULL (main + skid).
// All status outputs are registered, decoded from the next state.
module pipeline_stage_register #(
   parameter int unsigned N = 32,
   parameter logic [N-1:0] RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy,
   output logic [1:0]   fsm_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   main_data;
   logic [N-1:0]   skid_data;
   logic [N-1:0]   main_next;
   logic [N-1:0]   skid_next;
   logic           in_fire;
   logic           out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_data;
   assign fsm_state = state;

   // Next-state and next-data selection; flush overrides every transition.
   always_comb begin
      state_next = state;
      main_next  = main_data;
      skid_next  = skid_data;
      if (flush) begin
         // Held words and any word offered this cycle are discarded; the data
         // registers keep stale contents, which are hidden by out_valid=0.
         state_next = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_next  = in_data;
                  state_next = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_next  = in_data;
                  state_next = BUSY;
               end else if (in_fire) begin
                  // Downstream stalled: park the new word in the skid slot.
                  skid_next  = in_data;
                  state_next = FULL;
               end else if (out_fire) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  main_next  = skid_data;
                  state_next = BUSY;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   // State, data and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         main_data <= RESET_VALUE;
         skid_data <= RESET_VALUE;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
      end else begin
         state     <= state_next;
         main_data <= main_next;
         skid_data <= skid_next;
         unique case (state_next)
            EMPTY: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               occupancy <= 2'd0;
            end
            BUSY: begin
               out_valid <= 1'b1;
               in_ready  <= 1'b1;
               occupancy <= 2'd1;
            end
            FULL: begin
               out_valid <= 1'b1;
               in_ready  <= 1'b0;
               occupancy <= 2'd2;
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               occupancy <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
Parametrised successor to the plain enable register. It is a one-stage pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Breaks both the data path and the backpressure (ready) path, so in_ready has no combinational dependence on out_ready.
- Used between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) to support stalls and flushes without bubbles or lost words.

Parameters:
N, 32, data width in bits
RESET_VALUE, 0, value loaded into the main and skid data registers on reset (N bits)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream presents a word on in_data
in_ready  output  1  stage can accept a word this cycle
in_data  input  N  upstream data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts the word this cycle
out_data  output  N  data to downstream (main register)
occupancy  output  2  number of held words: 0, 1 or 2

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data, flag main_v) and skid register (flag skid_v).
- States: EMPTY (main_v=0, skid_v=0), BUSY (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1).
- Outputs are decoded from state only:
  - out_valid = main_v
  - in_ready = ~skid_v
  - occupancy = main_v + skid_v
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - state goes to EMPTY; main and skid data registers take RESET_VALUE.
  - out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE.
  - Held data is lost.
- Transitions (evaluated at rising clk, flush=0):
  - EMPTY: in_fire -> main<=in_data, BUSY; else hold.
  - BUSY, in_fire & out_fire -> main<=in_data, stay BUSY.
  - BUSY, in_fire only -> skid<=in_data, FULL.
  - BUSY, out_fire only -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: in_ready=0, so in_fire cannot occur. out_fire -> main<=skid, BUSY; else hold.
- Latency and throughput:
  - A word accepted at edge k appears on out_data with out_valid=1 after edge k (1 cycle).
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Ordering: strict FIFO. No word is duplicated, dropped or reordered, except by flush or reset.
- Flush (synchronous, priority over every transition):
  - At the edge, main_v and skid_v go to 0 and the state becomes EMPTY.
  - A word offered in the flush cycle is discarded, even though in_ready may read 1 that cycle.
  - Data registers may keep stale contents; out_data is don't-care while out_valid=0.
- in_valid may be held high with changing in_data while in_ready=0; only the data present on an in_fire edge is captured.
- Unused register contents never reach out_data while out_valid=0. The bench must not check out_data when out_valid=0, except right after reset.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release, in_valid=0 -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
2. Streaming: out_ready=1, drive 0x11,0x22,0x33 on consecutive cycles with in_valid=1 -> out_data shows 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy stays 1.
3. Backpressure to full:
   - Setup: out_ready=0, send 0xA1 then 0xA2.
   - After the 2nd edge: occupancy=2, in_ready=0, out_data=0xA1.
   - Offer 0xA3: not accepted.
   - Set out_ready=1: outputs 0xA1, 0xA2, then 0xA3 in order, with no loss or duplication.
4. Stall stability: BUSY with 0x5A, out_ready=0 for 5 cycles -> out_data=0x5A and out_valid=1 every cycle.
5. Flush while FULL:
   - Setup: hold 0xB1/0xB2; assert flush for 1 cycle while in_valid=1 with 0xB3.
   - Next cycle: out_valid=0, occupancy=0, in_ready=1.
   - 0xB3 never appears.
6. Async reset mid-stream: during test 2, pull reset low between clock edges -> out_valid and occupancy go to 0 immediately, out_data=RESET_VALUE. After release, a new word 0x77 passes with 1-cycle latency.
